// File: rtl/pill_fill_pkg.sv
// Shared codes for the pill-counting bottling controller: state codes,
// beeper modes and error causes.
package pill_fill_pkg;

  typedef enum logic [2:0] {
    ST_SETTING   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
  } state_t;

  localparam logic [1:0] BEEP_OFF  = 2'd0;
  localparam logic [1:0] BEEP_CONT = 2'd1;
  localparam logic [1:0] BEEP_SLOW = 2'd2;
  localparam logic [1:0] BEEP_FAST = 2'd3;

  localparam logic CAUSE_HOPPER   = 1'b0;
  localparam logic CAUSE_CONVEYOR = 1'b1;

  function automatic logic [1:0] beep_for(input state_t s);
    case (s)
      ST_DONE:  return BEEP_CONT;
      ST_ERROR: return BEEP_SLOW;
      ST_FATAL: return BEEP_FAST;
      default:  return BEEP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pill_fill_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear and an all-digit compare
// against a target, either on the current value or on the incremented value.
module bcd_counter
  import pill_fill_pkg::*;
#(
  parameter int unsigned DIGITS    = 3,
  parameter bit          LOOKAHEAD = 1'b0
) (
  input  logic                  clk_1khz,
  input  logic                  clr,
  input  logic                  sclr,
  input  logic                  inc,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count,
  output logic                  eq
);

  logic [4*DIGITS-1:0] nxt;
  logic                carry;

  always_comb begin
    nxt   = count;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    eq = (LOOKAHEAD ? nxt : count) == target;
  end

  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (sclr) begin
      count <= '0;
    end else if (inc) begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/pill_fill_ctrl.sv
// Bottling controller: counts synchronised hopper pulses into bottles, sequences
// conveyor changeover and supervises hopper starvation / conveyor stall.
module pill_fill_ctrl
  import pill_fill_pkg::*;
#(
  parameter int unsigned PILL_DIGITS   = 3,
  parameter int unsigned BOTTLE_DIGITS = 2,
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned SWITCH_SEC    = 2,
  parameter int unsigned HOPPER_SEC    = 3
) (
  input  logic                       clk_1khz,
  input  logic                       clr,
  input  logic                       estop,
  input  logic                       start,
  input  logic                       ack,
  input  logic                       pill_in,
  input  logic                       conveyor_ok,
  input  logic [4*PILL_DIGITS-1:0]   set_pills,
  input  logic [4*BOTTLE_DIGITS-1:0] set_bottles,
  output logic [2:0]                 state,
  output logic                       err_cause,
  output logic [4*PILL_DIGITS-1:0]   now_pills,
  output logic [4*BOTTLE_DIGITS-1:0] now_bottles,
  output logic                       bottle_done,
  output logic                       start_rej,
  output logic [1:0]                 beep_mode
);

  localparam int unsigned TMAX = (SWITCH_SEC > HOPPER_SEC) ? SWITCH_SEC : HOPPER_SEC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SW_LOAD  = TW'(SWITCH_SEC);
  localparam logic [TW-1:0] HOP_LOAD = TW'(HOPPER_SEC);

  state_t        st, st_nxt;
  logic          pill_s1, pill_s2, pill_s3, pill_edge;
  logic [DW-1:0] div;
  logic          tick;
  logic [TW-1:0] hop_tmr, sw_tmr;
  logic          hop_exp, sw_exp;
  logic          hop_load, sw_load;
  logic          pill_clr, pill_inc, pill_eq;
  logic          bot_clr, bot_inc, bot_last;
  logic          cause_nxt, done_nxt, rej_nxt;
  logic          cfg_ok;

  assign state     = st;
  assign pill_edge = pill_s2 & ~pill_s3;
  assign tick      = (div == DIV_LAST);
  assign hop_exp   = tick && (hop_tmr == '0);
  assign sw_exp    = tick && (sw_tmr == '0);

  bcd_counter #(.DIGITS(PILL_DIGITS), .LOOKAHEAD(1'b0)) u_pills (
    .clk_1khz (clk_1khz),
    .clr      (clr),
    .sclr     (pill_clr),
    .inc      (pill_inc),
    .target   (set_pills),
    .count    (now_pills),
    .eq       (pill_eq)
  );

  // Compares the would-be count so the last bottle is known in the completing cycle.
  bcd_counter #(.DIGITS(BOTTLE_DIGITS), .LOOKAHEAD(1'b1)) u_bottles (
    .clk_1khz (clk_1khz),
    .clr      (clr),
    .sclr     (bot_clr),
    .inc      (bot_inc),
    .target   (set_bottles),
    .count    (now_bottles),
    .eq       (bot_last)
  );

  always_comb begin
    cfg_ok = (set_pills != '0) && (set_bottles != '0);
    for (int unsigned i = 0; i < PILL_DIGITS; i++)
      if (set_pills[4*i +: 4] > 4'd9) cfg_ok = 1'b0;
    for (int unsigned i = 0; i < BOTTLE_DIGITS; i++)
      if (set_bottles[4*i +: 4] > 4'd9) cfg_ok = 1'b0;
  end

  always_comb begin
    st_nxt    = st;
    pill_clr  = 1'b0;
    pill_inc  = 1'b0;
    bot_clr   = 1'b0;
    bot_inc   = 1'b0;
    hop_load  = 1'b0;
    sw_load   = 1'b0;
    cause_nxt = err_cause;
    done_nxt  = 1'b0;
    rej_nxt   = 1'b0;
    if (estop) begin
      st_nxt = ST_FATAL;
    end else begin
      case (st)
        ST_SETTING: begin
          if (start) begin
            if (cfg_ok) begin
              st_nxt   = ST_RUNNING;
              pill_clr = 1'b1;
              bot_clr  = 1'b1;
              hop_load = 1'b1;
            end else begin
              rej_nxt = 1'b1;
            end
          end
        end
        ST_RUNNING: begin
          if (pill_eq) begin
            done_nxt = 1'b1;
            bot_inc  = 1'b1;
            if (bot_last) begin
              st_nxt = ST_DONE;
            end else begin
              st_nxt   = ST_SWITCHING;
              pill_clr = 1'b1;
              sw_load  = 1'b1;
            end
          end else if (pill_edge) begin
            pill_inc = 1'b1;
            hop_load = 1'b1;
          end else if (hop_exp) begin
            st_nxt    = ST_ERROR;
            cause_nxt = CAUSE_HOPPER;
          end
        end
        ST_SWITCHING: begin
          if (sw_exp) begin
            if (conveyor_ok) begin
              st_nxt   = ST_RUNNING;
              hop_load = 1'b1;
            end else begin
              st_nxt    = ST_ERROR;
              cause_nxt = CAUSE_CONVEYOR;
            end
          end
        end
        ST_ERROR: begin
          if (err_cause == CAUSE_HOPPER) begin
            if (pill_edge) begin
              st_nxt   = ST_RUNNING;
              pill_inc = 1'b1;
              hop_load = 1'b1;
            end
          end else if (conveyor_ok) begin
            st_nxt   = ST_RUNNING;
            hop_load = 1'b1;
          end
        end
        ST_DONE:  if (ack) st_nxt = ST_SETTING;
        ST_FATAL: if (ack) st_nxt = ST_SETTING;
        default:  st_nxt = ST_SETTING;
      endcase
    end
  end

  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      st          <= ST_SETTING;
      err_cause   <= CAUSE_HOPPER;
      bottle_done <= 1'b0;
      start_rej   <= 1'b0;
      beep_mode   <= BEEP_OFF;
      pill_s1     <= 1'b0;
      pill_s2     <= 1'b0;
      pill_s3     <= 1'b0;
      div         <= '0;
      hop_tmr     <= '0;
      sw_tmr      <= '0;
    end else begin
      st          <= st_nxt;
      err_cause   <= cause_nxt;
      bottle_done <= done_nxt;
      start_rej   <= rej_nxt;
      beep_mode   <= beep_for(st_nxt);
      pill_s1     <= pill_in;
      pill_s2     <= pill_s1;
      pill_s3     <= pill_s2;
      div         <= tick ? '0 : div + 1'b1;
      if (hop_load)                     hop_tmr <= HOP_LOAD;
      else if (tick && hop_tmr != '0)   hop_tmr <= hop_tmr - 1'b1;
      if (sw_load)                      sw_tmr  <= SW_LOAD;
      else if (tick && sw_tmr != '0)    sw_tmr  <= sw_tmr - 1'b1;
    end
  end

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// Directed-plus-randomised bench for pill_fill_ctrl with TICK_DIV=10,
// expected counts derived arithmetically from pill/bottle totals.
module tb_pill_fill_ctrl;

  localparam logic [2:0] ST_SETTING   = 3'd0;
  localparam logic [2:0] ST_RUNNING   = 3'd1;
  localparam logic [2:0] ST_SWITCHING = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_ERROR     = 3'd4;
  localparam logic [2:0] ST_FATAL     = 3'd5;

  logic        clk_1khz = 1'b0;
  logic        clr, estop, start, ack, pill_in, conveyor_ok;
  logic [11:0] set_pills;
  logic [7:0]  set_bottles;
  logic [2:0]  state;
  logic        err_cause, bottle_done, start_rej;
  logic [11:0] now_pills;
  logic [7:0]  now_bottles;
  logic [1:0]  beep_mode;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  int rej_pulses = 0;

  pill_fill_ctrl #(
    .PILL_DIGITS   (3),
    .BOTTLE_DIGITS (2),
    .TICK_DIV      (10),
    .SWITCH_SEC    (2),
    .HOPPER_SEC    (3)
  ) dut (
    .clk_1khz    (clk_1khz),
    .clr         (clr),
    .estop       (estop),
    .start       (start),
    .ack         (ack),
    .pill_in     (pill_in),
    .conveyor_ok (conveyor_ok),
    .set_pills   (set_pills),
    .set_bottles (set_bottles),
    .state       (state),
    .err_cause   (err_cause),
    .now_pills   (now_pills),
    .now_bottles (now_bottles),
    .bottle_done (bottle_done),
    .start_rej   (start_rej),
    .beep_mode   (beep_mode)
  );

  always #5 clk_1khz = ~clk_1khz;

  always @(posedge clk_1khz) begin
    #1;
    if (bottle_done === 1'b1) done_pulses++;
    if (start_rej === 1'b1)   rej_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  task automatic pill(input int low);
    pill_in = 1'b1;
    cyc(2);
    pill_in = 1'b0;
    cyc(low);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, output int n);
    n = 0;
    while (state !== s && n < maxc) begin
      cyc(1);
      n++;
    end
    check("wait_state", state, s);
  endtask

  // p pills per bottle, b bottles; a bottle completes one edge after its last pill counts.
  task automatic run_fill(input int p, input int b, input bit inject);
    int d0, n, low, dur;
    set_pills   = 12'(to_bcd(p));
    set_bottles = 8'(to_bcd(b));
    conveyor_ok = 1'b1;
    do_start();
    check("run_start_state", state, ST_RUNNING);
    check("run_start_pills", now_pills, 0);
    check("run_start_bottles", now_bottles, 0);
    for (int bi = 1; bi <= b; bi++) begin
      for (int k = 1; k <= p; k++) begin
        d0  = done_pulses;
        low = $urandom_range(2, 6);
        pill(low);
        if (k < p) begin
          check("pill_count", now_pills, to_bcd(k));
          check("pill_state", state, ST_RUNNING);
        end else begin
          check("bottle_pulse", done_pulses, d0 + 1);
          check("bottle_count", now_bottles, to_bcd(bi));
          if (bi == b) begin
            check("done_state", state, ST_DONE);
            check("done_pills", now_pills, to_bcd(p));
            check("done_beep", beep_mode, 1);
          end else begin
            check("switch_state", state, ST_SWITCHING);
            check("switch_pills", now_pills, 0);
            if (inject) pill(2);
            else        cyc(4);
            wait_state(ST_RUNNING, 40, n);
            dur = low + 2 + n;
            check("switch_dur_ok", (dur >= 21 && dur <= 30) ? 1 : 0, 1);
            check("resume_pills", now_pills, 0);
          end
        end
      end
    end
    do_ack();
    check("ack_state", state, ST_SETTING);
    check("ack_keep_pills", now_pills, to_bcd(p));
    check("ack_keep_bottles", now_bottles, to_bcd(b));
  endtask

  initial begin
    int n, d0, r0;
    clr = 1'b1; estop = 1'b0; start = 1'b0; ack = 1'b0; pill_in = 1'b0;
    conveyor_ok = 1'b1; set_pills = '0; set_bottles = '0;
    cyc(2);
    check("rst_state", state, ST_SETTING);
    check("rst_pills", now_pills, 0);
    check("rst_bottles", now_bottles, 0);
    check("rst_err", err_cause, 0);
    check("rst_done", bottle_done, 0);
    check("rst_rej", start_rej, 0);
    check("rst_beep", beep_mode, 0);
    clr = 1'b0;
    cyc(3);

    // normal run as in the reference scenario, then randomised runs
    run_fill(3, 2, 1'b0);
    repeat (4) run_fill($urandom_range(1, 12), $urandom_range(1, 3), 1'b1);

    // hopper starvation, recovery, then asynchronous clear mid-run
    set_pills = 12'h005; set_bottles = 8'h01;
    do_start();
    wait_state(ST_ERROR, 60, n);
    check("starve_time_ok", (n >= 31 && n <= 40) ? 1 : 0, 1);
    check("starve_cause", err_cause, 0);
    check("starve_beep", beep_mode, 2);
    pill(2);
    check("starve_recover_state", state, ST_RUNNING);
    check("starve_recover_pills", now_pills, 1);
    check("starve_recover_beep", beep_mode, 0);
    pill_in = 1'b1;
    cyc(1);
    #2 clr = 1'b1;
    #1;
    check("clr_state", state, ST_SETTING);
    check("clr_pills", now_pills, 0);
    check("clr_bottles", now_bottles, 0);
    check("clr_err", err_cause, 0);
    check("clr_done", bottle_done, 0);
    check("clr_beep", beep_mode, 0);
    @(negedge clk_1khz);
    clr = 1'b0;
    pill_in = 1'b0;
    cyc(3);
    check("clr_after_state", state, ST_SETTING);
    check("clr_after_pills", now_pills, 0);

    // conveyor stall during changeover
    set_pills = 12'h001; set_bottles = 8'h02;
    do_start();
    conveyor_ok = 1'b0;
    pill(2);
    check("stall_switch", state, ST_SWITCHING);
    wait_state(ST_ERROR, 40, n);
    check("stall_cause", err_cause, 1);
    check("stall_beep", beep_mode, 2);
    check("stall_bottles", now_bottles, 1);
    cyc(3);
    check("stall_hold", state, ST_ERROR);
    conveyor_ok = 1'b1;
    cyc(1);
    check("stall_resume", state, ST_RUNNING);
    check("stall_resume_pills", now_pills, 0);
    pill(2);
    check("stall_done", state, ST_DONE);
    check("stall_done_bottles", now_bottles, 2);
    do_ack();

    // emergency stop during changeover
    set_pills = 12'h002; set_bottles = 8'h03;
    do_start();
    pill(2);
    pill(2);
    check("estop_pre", state, ST_SWITCHING);
    cyc(2);
    estop = 1'b1;
    cyc(1);
    check("estop_state", state, ST_FATAL);
    check("estop_beep", beep_mode, 3);
    pill(2);
    cyc(30);
    check("estop_hold", state, ST_FATAL);
    check("estop_frozen_pills", now_pills, 0);
    check("estop_frozen_bottles", now_bottles, 1);
    do_ack();
    check("estop_ack_high", state, ST_FATAL);
    estop = 1'b0;
    cyc(1);
    check("estop_no_ack", state, ST_FATAL);
    do_ack();
    check("estop_release", state, ST_SETTING);
    check("estop_keep_bottles", now_bottles, 1);
    check("estop_beep_off", beep_mode, 0);

    // invalid configurations
    r0 = rej_pulses;
    set_pills = 12'h000; set_bottles = 8'h01;
    do_start();
    check("rej_zero_pills", rej_pulses, r0 + 1);
    check("rej_zero_state", state, ST_SETTING);
    set_pills = 12'h0A5;
    do_start();
    check("rej_bad_digit", rej_pulses, r0 + 2);
    check("rej_bad_state", state, ST_SETTING);
    set_pills = 12'h005; set_bottles = 8'h00;
    do_start();
    check("rej_zero_bottles", rej_pulses, r0 + 3);
    set_bottles = 8'h1F;
    do_start();
    cyc(2);
    check("rej_bad_bottles", rej_pulses, r0 + 4);
    check("rej_final_state", state, ST_SETTING);

    // start+ack together, then BCD carry through 99 -> 100
    set_pills = 12'h100; set_bottles = 8'h01;
    start = 1'b1; ack = 1'b1;
    cyc(1);
    start = 1'b0; ack = 1'b0;
    check("tie_start_wins", state, ST_RUNNING);
    check("tie_no_rej", rej_pulses, r0 + 4);
    for (int k = 1; k <= 99; k++) begin
      pill(2);
      check("bcd_count", now_pills, to_bcd(k));
    end
    d0 = done_pulses;
    pill(2);
    check("bcd_100", now_pills, 12'h100);
    check("bcd_done_pulse", done_pulses, d0 + 1);
    check("bcd_done_state", state, ST_DONE);
    check("bcd_bottles", now_bottles, 1);
    do_ack();
    check("bcd_ack", state, ST_SETTING);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pill_fill_ctrl.md
# pill_fill_ctrl

Parametrised bottling controller for the pill-counting station. It counts hopper pulses into bottles of a configured pill count until a configured bottle count is reached. It sequences bottle changeover on the conveyor and supervises hopper starvation and conveyor stall with second-based timeouts. It feeds the display/beeper layer with BCD counts, the state code and a beep mode.

## Interface
- `PILL_DIGITS`, 3: BCD digits of the pill target/count.
- `BOTTLE_DIGITS`, 2: BCD digits of the bottle target/count.
- `TICK_DIV`, 1000: `clk_1khz` cycles per 1 s timer tick.
- `SWITCH_SEC`, 2: changeover time in ticks (≥1).
- `HOPPER_SEC`, 3: maximum ticks between pills before starvation (≥1).
- `clk_1khz`, in, 1: single clock. Everything is rising-edge.
- `clr`, in, 1: reset, asynchronous, active-high.
- `estop`, in, 1: emergency stop, level.
- `start`, in, 1: one-cycle pulse; start a run from SETTING.
- `ack`, in, 1: one-cycle pulse; leave DONE/FATAL.
- `pill_in`, in, 1: hopper drop signal, asynchronous level; one rising edge counts as one pill.
- `conveyor_ok`, in, 1: conveyor running, level.
- `set_pills`, in, 4·PILL_DIGITS: BCD pill target.
- `set_bottles`, in, 4·BOTTLE_DIGITS: BCD bottle target.
- `state`, out, 3: current state code.
- `err_cause`, out, 1: 0 = hopper, 1 = conveyor. Valid in ERROR.
- `now_pills`, out, 4·PILL_DIGITS: pills in the current bottle, BCD.
- `now_bottles`, out, 4·BOTTLE_DIGITS: bottles completed, BCD.
- `bottle_done`, out, 1: one-cycle pulse per completed bottle.
- `start_rej`, out, 1: one-cycle pulse when a start is refused.
- `beep_mode`, out, 2: 0 off, 1 continuous, 2 slow (2 Hz), 3 fast (4 Hz).

## Operation
- States: SETTING=0, RUNNING=1, SWITCHING=2, DONE=3, ERROR=4, FATAL=5.
- `estop` high in any state causes FATAL on the next edge and has priority over every other event. Counts are frozen while in FATAL.
- **SETTING**
  - `start` with a valid configuration goes to RUNNING. Valid means every digit ≤9 and both targets are nonzero.
  - On that transition, `now_pills` and `now_bottles` clear and the hopper timer loads HOPPER_SEC.
  - `start` with an invalid configuration pulses `start_rej` and the block stays in SETTING.
- **RUNNING**
  - Each pill edge increments `now_pills` in BCD and reloads the hopper timer.
  - When registered `now_pills` equals `set_pills`:
    - `bottle_done` pulses and `now_bottles` increments.
    - If the new bottle count equals `set_bottles`, go to DONE. `now_pills` is held.
    - Otherwise go to SWITCHING. `now_pills` clears and the switch timer loads SWITCH_SEC.
  - If the hopper timer is at 0 on a tick, go to ERROR with `err_cause`=0.
- **SWITCHING**
  - Pill edges are ignored.
  - When the switch timer reaches 0 on a tick: if `conveyor_ok` is high, go to RUNNING and reload the hopper timer. Otherwise go to ERROR with `err_cause`=1.
- **ERROR**
  - With cause 0, a pill edge returns to RUNNING. That edge is counted and the timer is reloaded.
  - With cause 1, `conveyor_ok` high returns to RUNNING and the hopper timer is reloaded.
- **DONE:** `ack` goes to SETTING. Counts are retained for display until the next start.
- **FATAL:** `ack` with `estop` low goes to SETTING. Counts are retained.
- **BCD counters**
  - Digit 9+1 gives 0 with a carry into the next digit.
  - All-9s wraps to all-0 with no flag. This is unreachable with valid targets.
  - The target compare is an exact equality on all digits.
- **Beep mode:** DONE=1, ERROR=2, FATAL=3, else 0.
- **Tie-breaks when events coincide:**
  - In RUNNING, a pill edge and hopper expiry in the same cycle: the pill wins, and the timer reloads.
  - `start` and `ack` together in SETTING: `start` wins.

## Timing
- Reset state and outputs:
  - `state`=SETTING.
  - `now_pills` and `now_bottles` are all zero.
  - `err_cause`=0, `bottle_done`=0, `start_rej`=0, `beep_mode`=0.
  - Timers and the tick divider are 0.
  - Both `pill_in` sync flops are 0.
- `clr` asserted mid-run returns the block to the reset state immediately. Sequential state and outputs are asynchronous on `clr`; no pill is counted.
- `pill_in` path: 2-flop synchroniser, then an edge register.
  - If `pill_in` is high at edge k, `now_pills` updates at edge k+2.
  - A pill needs at least 2 cycles high and 2 cycles low.
- Completion latency: `now_pills` reaches the target at edge n. The state change and the `bottle_done` pulse occur at edge n+1.
- Tick divider:
  - Counts 0..TICK_DIV−1 and emits `tick` for one cycle at TICK_DIV−1.
  - Free-running; not realigned on state entry. First-tick jitter is therefore up to one tick.
- Timers:
  - A timer decrements on `tick` while nonzero.
  - It expires on the first `tick` that finds it at 0.
- `state`, `now_*`, `err_cause` and `beep_mode` are registered. `bottle_done` and `start_rej` are registered pulses.

## Structure
- Package `pill_fill_pkg` holds:
  - the state localparams (codes 0–5);
  - the beep_mode codes;
  - the `err_cause` codes.
- Sub-module `bcd_counter` #(DIGITS) provides synchronous clear, increment with per-digit carry and an all-digits `eq` compare.
  - It is instantiated twice: once for pills and once for bottles.
- The top level holds the FSM, the tick divider, the two second timers (width $clog2(max(SWITCH_SEC,HOPPER_SEC)+1)) and the pill synchroniser.

## Test plan
All scenarios run with TICK_DIV=10.
- **Normal run.** set_pills=0x003, set_bottles=0x02, start, then 6 pills spaced 5 cycles apart. Expect two `bottle_done` pulses, SWITCHING between bottles lasting about 20 cycles, and a final DONE with `now_bottles`=0x02, `now_pills`=0x003 and `beep_mode`=1.
- **Hopper starvation.** No pills after start. Expect ERROR with `err_cause`=0 and `beep_mode`=2 within 30–40 cycles. One pill then gives RUNNING with `now_pills`=0x001.
- **Conveyor stall.** `conveyor_ok`=0 through SWITCHING. Expect ERROR with `err_cause`=1. Raising `conveyor_ok` gives RUNNING on the next edge with `now_pills`=0.
- **Emergency stop.** `estop` during SWITCHING. Expect FATAL next edge and `beep_mode`=3. `ack` with `estop` high gives no change. `ack` after `estop` drops gives SETTING with counts unchanged.
- **Invalid configuration.** set_pills=0x000 or 0x0A5, then start. Expect a `start_rej` pulse and the block staying in SETTING.
- **BCD carry and mid-run reset.** set_pills=0x100 with 99 pills gives `now_pills`=0x099, and pill 100 gives 0x100 plus `bottle_done`. `clr` pulsed mid-run gives all outputs at reset values asynchronously.
